// File: rtl/demux1_4_buf.sv
// demux1_4_buf: registered 1-to-4 result router.
// Each destination has its own small FIFO with a valid/ready output.
module demux1_4_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    output logic             v3,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    input  logic             r3,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem    [4][DEPTH];
    logic [PW-1:0]    wr_ptr [4];
    logic [PW-1:0]    rd_ptr [4];
    logic [CW-1:0]    cnt    [4];
    logic [WIDTH-1:0] head   [4];
    logic [3:0]       vld;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [3:0]       r_vec;

    // Handshake decode and head-of-queue read for every channel
    always_comb begin
        r_vec    = {r3, r2, r1, r0};
        in_ready = (cnt[s] != FULL);
        vld      = '0;
        push     = '0;
        pop      = '0;
        for (int k = 0; k < 4; k++) begin
            head[k] = '0;
            vld[k]  = (cnt[k] != '0);
            pop[k]  = vld[k] && r_vec[k];
            push[k] = in_valid && in_ready && (s == 2'(k));
            if (vld[k]) begin
                head[k] = mem[k][rd_ptr[k]];
            end
        end
    end

    // Storage write; contents are left as-is across reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= din;
            end
        end
    end

    // Pointers and occupancy; reset empties every channel at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PW'(1);
                end
                if (push[k] && !pop[k]) begin
                    cnt[k] <= cnt[k] + CW'(1);
                end else if (!push[k] && pop[k]) begin
                    cnt[k] <= cnt[k] - CW'(1);
                end
            end
        end
    end

    assign y0   = head[0];
    assign y1   = head[1];
    assign y2   = head[2];
    assign y3   = head[3];
    assign v0   = vld[0];
    assign v1   = vld[1];
    assign v2   = vld[2];
    assign v3   = vld[3];
    assign busy = |vld;

endmodule

// File: tb/tb_demux1_4_buf.sv
// tb_demux1_4_buf: directed and random checks of demux1_4_buf
// against a four-queue reference model.
module tb_demux1_4_buf;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] din;
    logic [1:0]       s;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y0, y1, y2, y3;
    logic             v0, v1, v2, v3;
    logic             r0, r1, r2, r3;
    logic             busy;

    logic [WIDTH-1:0] yv [4];
    logic             vv [4];

    logic [WIDTH-1:0] q [4][$];

    int n_tests = 0;
    int n_fail  = 0;

    demux1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .s(s),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .busy(busy)
    );

    assign yv[0] = y0;
    assign yv[1] = y1;
    assign yv[2] = y2;
    assign yv[3] = y3;
    assign vv[0] = v0;
    assign vv[1] = v1;
    assign vv[2] = v2;
    assign vv[3] = v3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the queue model
    task automatic check_all(input string tag);
        bit any;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s v%0d", tag, k), 32'(vv[k]),
                  32'(q[k].size() != 0));
            check($sformatf("%s y%0d", tag, k), 32'(yv[k]),
                  (q[k].size() != 0) ? 32'(q[k][0]) : 32'h0);
            if (q[k].size() != 0) any = 1'b1;
        end
        check($sformatf("%s busy", tag), 32'(busy), 32'(any));
        check($sformatf("%s in_ready", tag), 32'(in_ready),
              32'(q[s].size() != DEPTH));
    endtask

    // Apply inputs for one cycle, check, then advance the model
    task automatic cycle(input string tag, input logic [WIDTH-1:0] d,
                         input logic [1:0] sel, input logic iv,
                         input logic [3:0] r, output bit acc);
        bit [3:0] pp;
        din = d;
        s = sel;
        in_valid = iv;
        {r3, r2, r1, r0} = r;
        #1;
        check_all(tag);
        acc = iv && (q[sel].size() != DEPTH);
        for (int k = 0; k < 4; k++) pp[k] = (q[k].size() != 0) && r[k];
        @(posedge clk);
        for (int k = 0; k < 4; k++) if (pp[k]) void'(q[k].pop_front());
        if (acc) q[sel].push_back(d);
        #1;
    endtask

    initial begin
        bit acc;
        logic [WIDTH-1:0] hd;
        logic [1:0]       hs;
        logic             hv;

        rst_n = 1'b0;
        din = '0;
        s = 2'b00;
        in_valid = 1'b0;
        {r3, r2, r1, r0} = 4'b0000;
        #3;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: single push to channel 0
        cycle("t1 push", 16'h000A, 2'b00, 1'b1, 4'b0000, acc);
        check("t1 accepted", 32'(acc), 32'd1);
        cycle("t1 hold", 16'h0000, 2'b00, 1'b0, 4'b0000, acc);
        check("t1 y0 direct", 32'(y0), 32'h000A);
        cycle("t1 drain", 16'h0000, 2'b00, 1'b0, 4'b0001, acc);

        // 2: one word to each of channels 1..3 with consumers ready
        cycle("t2 a", 16'h0014, 2'b01, 1'b1, 4'b1111, acc);
        cycle("t2 b", 16'h001E, 2'b10, 1'b1, 4'b1111, acc);
        cycle("t2 c", 16'h0028, 2'b11, 1'b1, 4'b1111, acc);
        cycle("t2 d", 16'h0000, 2'b00, 1'b0, 4'b1111, acc);
        cycle("t2 e", 16'h0000, 2'b00, 1'b0, 4'b1111, acc);

        // 3: fill channel 2, observe backpressure per select
        cycle("t3 p1", 16'h0001, 2'b10, 1'b1, 4'b0000, acc);
        cycle("t3 p2", 16'h0002, 2'b10, 1'b1, 4'b0000, acc);
        cycle("t3 full", 16'h0003, 2'b10, 1'b1, 4'b0000, acc);
        check("t3 full rejects", 32'(acc), 32'd0);
        cycle("t3 s0", 16'h0000, 2'b00, 1'b0, 4'b0000, acc);
        check("t3 ready s0", 32'(in_ready), 32'd1);
        cycle("t3 pop1", 16'h0000, 2'b10, 1'b0, 4'b0100, acc);
        check("t3 ready after pop", 32'(in_ready), 32'd1);
        check("t3 y2 second", 32'(y2), 32'h0002);
        cycle("t3 pop2", 16'h0000, 2'b10, 1'b0, 4'b0100, acc);

        // 4: simultaneous push/pop on channel 3, wrapping pointers
        cycle("t4 seed", 16'h00AA, 2'b11, 1'b1, 4'b0000, acc);
        for (int i = 0; i < 6; i++) begin
            cycle($sformatf("t4 pp%0d", i), 16'h00BB + 16'(i), 2'b11,
                  1'b1, 4'b1000, acc);
            check($sformatf("t4 y3 %0d", i), 32'(y3), 32'h00BB + 32'(i));
            check($sformatf("t4 v3 %0d", i), 32'(v3), 32'd1);
        end
        cycle("t4 drain", 16'h0000, 2'b11, 1'b0, 4'b1000, acc);

        // 5: asynchronous reset in the middle of a cycle
        cycle("t5 a", 16'h0101, 2'b00, 1'b1, 4'b0000, acc);
        cycle("t5 b", 16'h0102, 2'b00, 1'b1, 4'b0000, acc);
        cycle("t5 c", 16'h0201, 2'b01, 1'b1, 4'b0000, acc);
        din = '0;
        in_valid = 1'b0;
        s = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) q[k].delete();
        check_all("t5 async");
        check("t5 busy", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("t5 post%0d", i), 16'h0000, 2'b00, 1'b0,
                  4'b1111, acc);
        end

        // 6: random traffic; the source holds a rejected word
        hv = 1'b0;
        hd = '0;
        hs = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 99) < 60);
                hd = WIDTH'($urandom);
                hs = 2'($urandom_range(0, 3));
            end
            cycle("rnd", hd, hs, hv, 4'($urandom), acc);
            if (acc) hv = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            cycle("rnd drain", 16'h0000, 2'b00, 1'b0, 4'b1111, acc);
        end
        check("end empty busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
